// File: rtl/corevx_tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : corevx_tlb_pkg
// Brief    : Shared Sv32 widths, PTE bit positions and walker state encoding
// Revision : 1.0 - initial release
// ============================================================================
package corevx_tlb_pkg;

    // Sv32 geometry
    localparam int VPN_W   = 20;
    localparam int PPN_W   = 22;
    localparam int PTE_W   = 32;
    localparam int TAG_W   = 8;
    localparam int MEM_AW  = 34;
    localparam int LEVELS  = 2;
    localparam int LVL_W   = $clog2(LEVELS);

    // PTE flag bit positions
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W_BIT = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    // Walker states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOOKUP = 4'd1,
        ST_WAIT   = 4'd2,
        ST_L1_REQ = 4'd3,
        ST_L0_REQ = 4'd4,
        ST_REFILL = 4'd5,
        ST_RESP   = 4'd6,
        ST_FLUSH  = 4'd7
    } ptw_state_e;

endpackage : corevx_tlb_pkg
`default_nettype wire

// File: rtl/corevx_pte_check.sv
`default_nettype none
// ============================================================================
// Module   : corevx_pte_check
// Brief    : Classifies a fetched Sv32 PTE as invalid / leaf / misaligned /
//            pointer for the level it was fetched at
// Revision : 1.0 - initial release
// ============================================================================
module corevx_pte_check
    import corevx_tlb_pkg::*;
(
    input  logic [PTE_W-1:0] pte_i,
    input  logic [LVL_W-1:0] level_i,
    output logic             invalid_o,
    output logic             leaf_o,
    output logic             misaligned_o,
    output logic             pointer_o
);

    // A/D/G/U, RSW and upper PPN bits do not affect classification
    logic w_unused_bits;
    assign w_unused_bits = ^{pte_i[31:20], pte_i[9:4]};

    // Classification: W without R is a reserved encoding and counts as invalid;
    // a superpage leaf must have its low PPN slice clear
    always_comb begin
        invalid_o    = ~pte_i[PTE_V] | (pte_i[PTE_W_BIT] & ~pte_i[PTE_R]);
        leaf_o       = ~invalid_o & (pte_i[PTE_R] | pte_i[PTE_X]);
        pointer_o    = ~invalid_o & ~leaf_o;
        misaligned_o = leaf_o & (level_i == LVL_W'(LEVELS - 1)) & (|pte_i[19:10]);
    end

endmodule : corevx_pte_check
`default_nettype wire

// File: rtl/corevx_tlb_ptw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : corevx_tlb_ptw_ctrl
// Brief    : Translation sequencer: TLB lookup, Sv32 two-level page-table
//            walk on miss, TLB refill and sfence.vma invalidation
// Revision : 1.0 - initial release
// ============================================================================
module corevx_tlb_ptw_ctrl
    import corevx_tlb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              satp_mode_i,
    input  logic [PPN_W-1:0]  satp_ppn_i,
    input  logic              req_i,
    input  logic [VPN_W-1:0]  req_vpn_i,
    input  logic              flush_i,
    output logic              flush_done_o,
    output logic              resp_done_o,
    output logic [PPN_W-1:0]  resp_phys_o,
    output logic [TAG_W-1:0]  resp_accesstag_o,
    output logic              resp_pagefault_o,
    output logic              resp_accessfault_o,
    output logic              tlb_enable_o,
    output logic              tlb_resolve_o,
    output logic              tlb_write_o,
    output logic              tlb_invalidate_o,
    output logic [VPN_W-1:0]  tlb_vaddr_o,
    output logic [VPN_W-1:0]  tlb_vaddr_w_o,
    output logic [PPN_W-1:0]  tlb_phys_w_o,
    output logic [TAG_W-1:0]  tlb_accesstag_w_o,
    input  logic              tlb_done_i,
    input  logic              tlb_miss_i,
    input  logic [PPN_W-1:0]  tlb_phys_r_i,
    input  logic [TAG_W-1:0]  tlb_accesstag_r_i,
    output logic              mem_read_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic              mem_done_i,
    input  logic [PTE_W-1:0]  mem_rdata_i,
    input  logic              mem_error_i
);

    ptw_state_e       state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [PPN_W-1:0] base_q, base_d;     // level-0 table PPN from the L1 pointer
    logic [PPN_W-1:0] phys_q, phys_d;     // leaf translation awaiting refill
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             pend_q, pend_d;     // flush seen while busy
    logic [PPN_W-1:0] resp_phys_q;
    logic [TAG_W-1:0] resp_tag_q;
    logic             resp_pf_q, resp_af_q;

    logic             w_ld_resp;
    logic [PPN_W-1:0] w_resp_phys;
    logic [TAG_W-1:0] w_resp_tag;
    logic             w_resp_pf, w_resp_af;
    logic             w_lvl1;
    logic             w_pte_invalid, w_pte_leaf, w_pte_misaligned, w_pte_pointer;

    assign w_lvl1 = (state_q == ST_L1_REQ);

    corevx_pte_check u_pte_check (
        .pte_i        (mem_rdata_i),
        .level_i      (LVL_W'(w_lvl1)),
        .invalid_o    (w_pte_invalid),
        .leaf_o       (w_pte_leaf),
        .misaligned_o (w_pte_misaligned),
        .pointer_o    (w_pte_pointer)
    );

    assign tlb_enable_o       = satp_mode_i;
    assign tlb_vaddr_o        = vpn_q;
    assign tlb_vaddr_w_o      = vpn_q;
    assign tlb_phys_w_o       = phys_q;
    assign tlb_accesstag_w_o  = tag_q;
    assign resp_phys_o        = resp_phys_q;
    assign resp_accesstag_o   = resp_tag_q;
    assign resp_pagefault_o   = resp_pf_q;
    assign resp_accessfault_o = resp_af_q;

    // State and datapath registers; response fields load on entry to RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vpn_q       <= '0;
            base_q      <= '0;
            phys_q      <= '0;
            tag_q       <= '0;
            pend_q      <= 1'b0;
            resp_phys_q <= '0;
            resp_tag_q  <= '0;
            resp_pf_q   <= 1'b0;
            resp_af_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            base_q  <= base_d;
            phys_q  <= phys_d;
            tag_q   <= tag_d;
            pend_q  <= pend_d;
            if (w_ld_resp) begin
                resp_phys_q <= w_resp_phys;
                resp_tag_q  <= w_resp_tag;
                resp_pf_q   <= w_resp_pf;
                resp_af_q   <= w_resp_af;
            end
        end
    end

    // Next-state, TLB/memory strobes and response selection
    always_comb begin
        state_d          = state_q;
        vpn_d            = vpn_q;
        base_d           = base_q;
        phys_d           = phys_q;
        tag_d            = tag_q;
        pend_d           = pend_q;
        w_ld_resp        = 1'b0;
        w_resp_phys      = '0;
        w_resp_tag       = '0;
        w_resp_pf        = 1'b0;
        w_resp_af        = 1'b0;
        flush_done_o     = 1'b0;
        resp_done_o      = 1'b0;
        tlb_resolve_o    = 1'b0;
        tlb_write_o      = 1'b0;
        tlb_invalidate_o = 1'b0;
        mem_read_o       = 1'b0;
        mem_addr_o       = '0;

        // A flush during a translation waits until the translation finishes
        if (flush_i && (state_q != ST_IDLE) && (state_q != ST_FLUSH)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (flush_i || pend_q) begin
                    state_d = ST_FLUSH;
                end else if (req_i) begin
                    vpn_d   = req_vpn_i;
                    state_d = ST_LOOKUP;
                end
            end
            ST_FLUSH: begin
                tlb_invalidate_o = 1'b1;
                flush_done_o     = 1'b1;
                pend_d           = 1'b0;
                state_d          = ST_IDLE;
            end
            ST_LOOKUP: begin
                if (!satp_mode_i) begin
                    // Bare mode: identity map with full permissions
                    w_ld_resp   = 1'b1;
                    w_resp_phys = {2'b00, vpn_q};
                    w_resp_tag  = 8'hFF;
                    state_d     = ST_RESP;
                end else begin
                    tlb_resolve_o = 1'b1;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tlb_done_i) begin
                    if (tlb_miss_i) begin
                        state_d = ST_L1_REQ;
                    end else begin
                        w_ld_resp   = 1'b1;
                        w_resp_phys = tlb_phys_r_i;
                        w_resp_tag  = tlb_accesstag_r_i;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_L1_REQ, ST_L0_REQ: begin
                mem_read_o = 1'b1;
                mem_addr_o = w_lvl1 ? {satp_ppn_i, vpn_q[19:10], 2'b00}
                                    : {base_q, vpn_q[9:0], 2'b00};
                if (mem_done_i) begin
                    if (mem_error_i) begin
                        w_ld_resp = 1'b1;
                        w_resp_af = 1'b1;
                        state_d   = ST_RESP;
                    end else if (w_pte_invalid || w_pte_misaligned ||
                                 (w_pte_pointer && !w_lvl1)) begin
                        w_ld_resp = 1'b1;
                        w_resp_pf = 1'b1;
                        state_d   = ST_RESP;
                    end else if (w_pte_leaf) begin
                        // Megapage leaf keeps the low VPN slice as page offset
                        phys_d  = w_lvl1 ? {mem_rdata_i[31:20], vpn_q[9:0]}
                                         : mem_rdata_i[31:10];
                        tag_d   = mem_rdata_i[7:0];
                        state_d = ST_REFILL;
                    end else begin
                        base_d  = mem_rdata_i[31:10];
                        state_d = ST_L0_REQ;
                    end
                end
            end
            ST_REFILL: begin
                tlb_write_o = 1'b1;
                w_ld_resp   = 1'b1;
                w_resp_phys = phys_q;
                w_resp_tag  = tag_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                resp_done_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : corevx_tlb_ptw_ctrl
`default_nettype wire

// File: tb/tb_corevx_tlb_ptw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_corevx_tlb_ptw_ctrl
// Brief    : Directed bench with a small behavioural TLB and a page-table
//            memory model with programmable latency and error injection
// Revision : 1.0 - initial release
// ============================================================================
module tb_corevx_tlb_ptw_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        satp_mode = 1'b0;
    logic [21:0] satp_ppn = '0;
    logic        req = 1'b0;
    logic [19:0] req_vpn = '0;
    logic        flush = 1'b0;
    logic        flush_done, resp_done;
    logic [21:0] resp_phys;
    logic [7:0]  resp_accesstag;
    logic        resp_pagefault, resp_accessfault;
    logic        tlb_enable, tlb_resolve, tlb_write, tlb_invalidate;
    logic [19:0] tlb_vaddr, tlb_vaddr_w;
    logic [21:0] tlb_phys_w;
    logic [7:0]  tlb_accesstag_w;
    logic        tlb_done, tlb_miss;
    logic [21:0] tlb_phys_r;
    logic [7:0]  tlb_accesstag_r;
    logic        mem_read;
    logic [33:0] mem_addr;
    logic        mem_done, mem_error;
    logic [31:0] mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    corevx_tlb_ptw_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .satp_mode_i        (satp_mode),
        .satp_ppn_i         (satp_ppn),
        .req_i              (req),
        .req_vpn_i          (req_vpn),
        .flush_i            (flush),
        .flush_done_o       (flush_done),
        .resp_done_o        (resp_done),
        .resp_phys_o        (resp_phys),
        .resp_accesstag_o   (resp_accesstag),
        .resp_pagefault_o   (resp_pagefault),
        .resp_accessfault_o (resp_accessfault),
        .tlb_enable_o       (tlb_enable),
        .tlb_resolve_o      (tlb_resolve),
        .tlb_write_o        (tlb_write),
        .tlb_invalidate_o   (tlb_invalidate),
        .tlb_vaddr_o        (tlb_vaddr),
        .tlb_vaddr_w_o      (tlb_vaddr_w),
        .tlb_phys_w_o       (tlb_phys_w),
        .tlb_accesstag_w_o  (tlb_accesstag_w),
        .tlb_done_i         (tlb_done),
        .tlb_miss_i         (tlb_miss),
        .tlb_phys_r_i       (tlb_phys_r),
        .tlb_accesstag_r_i  (tlb_accesstag_r),
        .mem_read_o         (mem_read),
        .mem_addr_o         (mem_addr),
        .mem_done_i         (mem_done),
        .mem_rdata_i        (mem_rdata),
        .mem_error_i        (mem_error)
    );

    // ---------------- behavioural 4-entry TLB ----------------
    logic [19:0] t_vpn  [4];
    logic [21:0] t_phys [4];
    logic [7:0]  t_tag  [4];
    logic        t_val  [4];
    int          t_ptr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tlb_done <= 1'b0; tlb_miss <= 1'b0; tlb_phys_r <= '0; tlb_accesstag_r <= '0;
            t_ptr <= 0;
            for (int i = 0; i < 4; i++) t_val[i] <= 1'b0;
        end else begin
            tlb_done <= 1'b0;
            if (tlb_invalidate) for (int i = 0; i < 4; i++) t_val[i] <= 1'b0;
            if (tlb_write) begin
                t_vpn[t_ptr] <= tlb_vaddr_w; t_phys[t_ptr] <= tlb_phys_w;
                t_tag[t_ptr] <= tlb_accesstag_w; t_val[t_ptr] <= 1'b1;
                t_ptr <= (t_ptr + 1) % 4;
            end
            if (tlb_resolve && tlb_enable) begin
                tlb_done <= 1'b1; tlb_miss <= 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (t_val[i] && t_vpn[i] == tlb_vaddr) begin
                        tlb_miss <= 1'b0; tlb_phys_r <= t_phys[i]; tlb_accesstag_r <= t_tag[i];
                    end
                end
            end
        end
    end

    // ---------------- page-table memory model ----------------
    logic [31:0] mem [logic [33:0]];
    logic [33:0] err_addr = 34'h3_FFFF_FFFF;
    int          mem_lat = 0;
    int          mcnt;
    logic [33:0] rd_log [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_done <= 1'b0; mem_error <= 1'b0; mem_rdata <= '0; mcnt <= 0;
        end else begin
            mem_done <= 1'b0; mem_error <= 1'b0;
            if (mem_read && !mem_done) begin
                if (mcnt >= mem_lat) begin
                    mem_done  <= 1'b1;
                    mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    mem_error <= (mem_addr == err_addr);
                    mcnt      <= 0;
                    rd_log.push_back(mem_addr);
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    // Event counters sampled before the edge updates state
    int wr_cnt = 0, res_cnt = 0, flush_cnt = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (tlb_write)   wr_cnt++;
            if (tlb_resolve) res_cnt++;
            if (flush_done)  flush_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_done && n < 200);
        if (!resp_done) check("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_flush(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!flush_done && n < 200);
        if (!flush_done) check("flush_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input logic [19:0] vpn, output int lat, output logic [21:0] phys,
                          output logic [7:0] tag, output logic pf, output logic af);
        @(negedge clk);
        req = 1'b1; req_vpn = vpn;
        wait_resp(lat);
        phys = resp_phys; tag = resp_accesstag; pf = resp_pagefault; af = resp_accessfault;
        req = 1'b0;
    endtask

    function automatic logic all_out_zero();
        return ~|{flush_done, resp_done, resp_phys, resp_accesstag, resp_pagefault,
                  resp_accessfault, tlb_resolve, tlb_write, tlb_invalidate, tlb_vaddr,
                  tlb_vaddr_w, tlb_phys_w, tlb_accesstag_w, mem_read, mem_addr};
    endfunction

    int          lat, r0, w0, f0, c0, n;
    logic [21:0] phys;
    logic [7:0]  tag;
    logic        pf, af;
    logic        found;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 64'(all_out_zero()), 64'd1);
        check("reset_tlb_enable", 64'(tlb_enable), 64'd0);
        rst = 1'b0;

        // Bare mode
        r0 = rd_log.size();
        do_req(20'h12345, lat, phys, tag, pf, af);
        check("bare_latency", 64'(lat), 64'd2);
        check("bare_phys", 64'(phys), 64'h012345);
        check("bare_tag", 64'(tag), 64'hFF);
        check("bare_faults", 64'({pf, af}), 64'd0);
        check("bare_no_mem", 64'(rd_log.size()), 64'(r0));

        // Two-level miss walk
        mem[34'h100200] = 32'h0008_0001;   // pointer to PPN 0x200
        mem[34'h200004] = 32'h0400_04CF;   // leaf PPN 0x10001, tag CF
        satp_mode = 1'b1; satp_ppn = 22'h100; mem_lat = 1;
        r0 = rd_log.size(); w0 = wr_cnt;
        do_req(20'h20001, lat, phys, tag, pf, af);
        check("miss_phys", 64'(phys), 64'h10001);
        check("miss_tag", 64'(tag), 64'hCF);
        check("miss_faults", 64'({pf, af}), 64'd0);
        check("miss_reads", 64'(rd_log.size() - r0), 64'd2);
        check("miss_l1_addr", 64'(rd_log[r0]), 64'h100200);
        check("miss_l0_addr", 64'(rd_log[r0 + 1]), 64'h200004);
        check("miss_refill", 64'(wr_cnt - w0), 64'd1);

        // Hit on the refilled entry
        r0 = rd_log.size();
        do_req(20'h20001, lat, phys, tag, pf, af);
        check("hit_latency", 64'(lat), 64'd3);
        check("hit_phys", 64'(phys), 64'h10001);
        check("hit_tag", 64'(tag), 64'hCF);
        check("hit_no_mem", 64'(rd_log.size()), 64'(r0));

        // Megapage leaf, aligned then misaligned
        mem[34'h100000] = 32'h0010_00CB;   // leaf PPN 0x400
        w0 = wr_cnt;
        do_req(20'h00123, lat, phys, tag, pf, af);
        check("mega_phys", 64'(phys), 64'h000523);
        check("mega_tag", 64'(tag), 64'hCB);
        check("mega_refill", 64'(wr_cnt - w0), 64'd1);
        mem[34'h100000] = 32'h0010_04CB;   // leaf PPN 0x401
        w0 = wr_cnt;
        do_req(20'h00124, lat, phys, tag, pf, af);
        check("mega_misalign_pf", 64'({pf, af}), 64'b10);
        check("mega_misalign_nowrite", 64'(wr_cnt - w0), 64'd0);

        // Invalid L1 PTE
        r0 = rd_log.size(); w0 = wr_cnt;
        do_req(20'h00C00, lat, phys, tag, pf, af);
        check("l1_invalid_pf", 64'({pf, af}), 64'b10);
        check("l1_invalid_reads", 64'(rd_log.size() - r0), 64'd1);
        check("l1_invalid_nowrite", 64'(wr_cnt - w0), 64'd0);

        // Memory error on the L0 read
        mem[34'h200008] = 32'h0400_04CF;
        err_addr = 34'h200008;
        r0 = rd_log.size(); w0 = wr_cnt;
        do_req(20'h20002, lat, phys, tag, pf, af);
        check("l0_error_af", 64'({pf, af}), 64'b01);
        check("l0_error_reads", 64'(rd_log.size() - r0), 64'd2);
        check("l0_error_nowrite", 64'(wr_cnt - w0), 64'd0);
        err_addr = 34'h3_FFFF_FFFF;

        // Flush during a walk, then re-request the same page
        mem[34'h20000C] = 32'h00CC_CCC7;   // leaf PPN 0x3333, tag C7
        mem_lat = 3;
        @(negedge clk);
        req = 1'b1; req_vpn = 20'h20003;
        r0 = rd_log.size();
        repeat (3) @(negedge clk);
        flush = 1'b1;
        f0 = flush_cnt;
        wait_resp(n);
        check("flush_waits_for_resp", 64'(flush_cnt - f0), 64'd0);
        check("flush_walk_phys", 64'(resp_phys), 64'h3333);
        c0 = res_cnt;
        wait_flush(n);
        check("flush_before_lookup", 64'(res_cnt - c0), 64'd0);
        flush = 1'b0;
        wait_resp(n);
        req = 1'b0;
        check("rewalk_reads", 64'(rd_log.size() - r0), 64'd4);
        check("rewalk_phys", 64'(resp_phys), 64'h3333);

        // Reset in the middle of the L0 read
        mem[34'h200014] = 32'h0400_04CF;
        mem_lat = 6;
        @(negedge clk);
        req = 1'b1; req_vpn = 20'h20005;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (mem_read && mem_addr == 34'h200014) found = 1'b1;
        end
        check("reach_l0_read", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        check("midwalk_reset_zero", 64'(all_out_zero()), 64'd1);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Recovery after reset
        satp_mode = 1'b0;
        do_req(20'h0ABCD, lat, phys, tag, pf, af);
        check("post_reset_latency", 64'(lat), 64'd2);
        check("post_reset_phys", 64'(phys), 64'h00ABCD);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_corevx_tlb_ptw_ctrl
`default_nettype wire
